sprite_pixel_fifo: RTL and testbench

//  Parametrised pixel FIFO for the PPU pixel pipeline, successor to the single-use sprite FIFO.

---
 rtl/sprite_pixel_fifo_pkg.sv | 21 ++
 rtl/sprite_pixel_fifo_row_merge.sv | 60 ++++++
 rtl/sprite_pixel_fifo.sv | 164 ++++++++++++++++
 tb/tb_sprite_pixel_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pixel_fifo_pkg.sv
// Shared types and defaults for the PPU pixel FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default pixel/attribute/row widths, the transparent colour
// index and the default-width FIFO entry struct.
package sprite_fifo_pkg;

    localparam int DEF_PIX_W   = 2;
    localparam int DEF_ATTR_W  = 2;
    localparam int DEF_ROW_LEN = 8;

    // Colour index 0 is see-through; mixing treats it as "slot free".
    localparam logic [DEF_PIX_W-1:0] PIX_TRANSPARENT = '0;

    typedef struct packed {
        logic [DEF_PIX_W-1:0]  color;
        logic [DEF_ATTR_W-1:0] attr;
    } pix_entry_t;

endpackage

// File: rtl/sprite_pixel_fifo_row_merge.sv
// Orders an incoming tile row and decides which of its slots get written.
// Latency: combinational.
// Backpressure: none; the caller only uses the outputs on an accepted push.
//
// Ports:
//   row_color  ROW_LEN pixels as fetched, pixel 0 in the low bits
//   flip       reverse pixel order (pixel ROW_LEN-1 becomes slot 0)
//   mix        overlay the row onto the queued window instead of appending
//   win_color  colours currently stored at head+0..head+ROW_LEN-1
//   win_count  how many of those window slots hold live entries
//   wr_color   slot-ordered colours to write
//   wr_en      per-slot write enable
module pixel_row_merge
    import sprite_fifo_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int ROW_LEN = DEF_ROW_LEN,
    parameter int OCC_W   = 5
) (
    input  logic [ROW_LEN*PIX_W-1:0] row_color,
    input  logic                     flip,
    input  logic                     mix,
    input  logic [ROW_LEN*PIX_W-1:0] win_color,
    input  logic [OCC_W-1:0]         win_count,
    output logic [ROW_LEN*PIX_W-1:0] wr_color,
    output logic [ROW_LEN-1:0]       wr_en
);

    localparam logic [PIX_W-1:0] TRANSP = PIX_W'(PIX_TRANSPARENT);

    logic [ROW_LEN*PIX_W-1:0] row_ord;

    // Slot k holds the k-th pixel to be shown, after optional flip.
    always_comb begin
        row_ord = '0;
        for (int k = 0; k < ROW_LEN; k++) begin
            if (flip) begin
                row_ord[k*PIX_W +: PIX_W] = row_color[(ROW_LEN-1-k)*PIX_W +: PIX_W];
            end else begin
                row_ord[k*PIX_W +: PIX_W] = row_color[k*PIX_W +: PIX_W];
            end
        end
    end

    // Appends write every slot. A mix only touches live slots where the
    // existing pixel is transparent and the new one is not, so the earlier
    // (higher priority) sprite stays on top; slots past the live window
    // are plain appends.
    always_comb begin
        wr_color = row_ord;
        wr_en    = '1;
        for (int k = 0; k < ROW_LEN; k++) begin
            if (mix && (k < int'(win_count))) begin
                wr_en[k] = (win_color[k*PIX_W +: PIX_W] == TRANSP) &&
                           (row_ord[k*PIX_W +: PIX_W] != TRANSP);
            end
        end
    end

endmodule

// File: rtl/sprite_pixel_fifo.sv
// Pixel FIFO: accepts whole tile rows, emits one pixel per T-cycle tick.
// Latency: popped pixel is registered, valid one clk after its pop tick.
// Backpressure: push_ready_out drops once a full row no longer fits.
//
// Optional feature: define SPRITE_FIFO_MIX_EN to add mix_in (sprite overlay).
// Ports:
//   clk_in, rst_n_in             clock, async active-low reset
//   tick_in                      T-cycle enable for push and pop
//   flush_in                     synchronous clear, independent of tick_in
//   push_valid_in/push_ready_out row handshake
//   row_color_in, row_attr_in    row pixels and shared attributes
//   flip_in                      horizontal flip of the row
//   pop_in                       pixel request
//   pixel_valid_out/_color/_attr popped pixel (1-clk valid pulse)
//   occupancy_out, empty_out     fill level
//   err_out                      sticky [0] push overflow, [1] pop underflow
module sprite_pixel_fifo
    import sprite_fifo_pkg::*;
#(
    parameter int PIX_W   = DEF_PIX_W,
    parameter int ATTR_W  = DEF_ATTR_W,
    parameter int ROW_LEN = DEF_ROW_LEN,
    parameter int DEPTH   = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       tick_in,
    input  logic                       flush_in,
    input  logic                       push_valid_in,
    output logic                       push_ready_out,
    input  logic [ROW_LEN*PIX_W-1:0]   row_color_in,
    input  logic [ATTR_W-1:0]          row_attr_in,
    input  logic                       flip_in,
    input  logic                       pop_in,
`ifdef SPRITE_FIFO_MIX_EN
    input  logic                       mix_in,
`endif
    output logic                       pixel_valid_out,
    output logic [PIX_W-1:0]           pixel_color_out,
    output logic [ATTR_W-1:0]          pixel_attr_out,
    output logic [$clog2(DEPTH):0]     occupancy_out,
    output logic                       empty_out,
    output logic [1:0]                 err_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PIX_W-1:0]  color;
        logic [ATTR_W-1:0] attr;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, head_nx, base_ptr, wr_nx;
    logic [OCC_W-1:0] occ, occ_pp, occ_nx;
    logic             pop_fire, push_fire, pop_err, push_err, mix_push;

    logic [ROW_LEN*PIX_W-1:0] win_color, wr_color;
    logic [ROW_LEN-1:0]       wr_en;

    assign push_ready_out = (occ <= OCC_W'(DEPTH - ROW_LEN));
    assign pop_fire       = tick_in && pop_in && (occ != '0);
    assign pop_err        = tick_in && pop_in && (occ == '0);
    assign push_fire      = tick_in && push_valid_in && push_ready_out;
    assign push_err       = tick_in && push_valid_in && !push_ready_out;

`ifdef SPRITE_FIFO_MIX_EN
    assign mix_push = push_fire && mix_in;
`else
    assign mix_push = 1'b0;
`endif

    // Head and fill level as seen after any same-tick pop; a mix overlays
    // from here, so the pixel leaving this tick is never overlaid.
    assign head_nx = rd_ptr + PTR_W'(pop_fire);
    assign occ_pp  = occ - OCC_W'(pop_fire);

    // For a mix, head'+occ' equals wr_ptr, so one base covers both the
    // overlay slots and the appended tail.
    assign base_ptr = mix_push ? head_nx : wr_ptr;

    always_comb begin
        win_color = '0;
        for (int k = 0; k < ROW_LEN; k++) begin
            win_color[k*PIX_W +: PIX_W] = mem[head_nx + PTR_W'(k)].color;
        end
    end

    pixel_row_merge #(
        .PIX_W   (PIX_W),
        .ROW_LEN (ROW_LEN),
        .OCC_W   (OCC_W)
    ) u_merge (
        .row_color (row_color_in),
        .flip      (flip_in),
        .mix       (mix_push),
        .win_color (win_color),
        .win_count (occ_pp),
        .wr_color  (wr_color),
        .wr_en     (wr_en)
    );

    always_comb begin
        occ_nx = occ_pp;
        wr_nx  = wr_ptr;
        if (push_fire) begin
            if (mix_push) begin
                occ_nx = (occ_pp > OCC_W'(ROW_LEN)) ? occ_pp : OCC_W'(ROW_LEN);
                // A full queue gives low bits 0, i.e. wr_ptr lands on head.
                wr_nx  = head_nx + occ_nx[PTR_W-1:0];
            end else begin
                occ_nx = occ_pp + OCC_W'(ROW_LEN);
                wr_nx  = wr_ptr + PTR_W'(ROW_LEN);
            end
        end
    end

    // Storage has no reset; gating on rst_n_in keeps a push that coincides
    // with reset from landing in the array.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && push_fire && !flush_in) begin
            for (int k = 0; k < ROW_LEN; k++) begin
                if (wr_en[k]) begin
                    mem[base_ptr + PTR_W'(k)].color <= wr_color[k*PIX_W +: PIX_W];
                    mem[base_ptr + PTR_W'(k)].attr  <= row_attr_in;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            occ             <= '0;
            pixel_valid_out <= 1'b0;
            pixel_color_out <= '0;
            pixel_attr_out  <= '0;
            err_out         <= '0;
        end else if (flush_in) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            occ             <= '0;
            pixel_valid_out <= 1'b0;
            err_out         <= '0;
        end else begin
            pixel_valid_out <= pop_fire;
            if (pop_fire) begin
                pixel_color_out <= mem[rd_ptr].color;
                pixel_attr_out  <= mem[rd_ptr].attr;
            end
            rd_ptr  <= head_nx;
            wr_ptr  <= wr_nx;
            occ     <= occ_nx;
            err_out <= err_out | {pop_err, push_err};
        end
    end

    assign occupancy_out = occ;
    assign empty_out     = (occ == '0);

endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Directed bench for sprite_pixel_fifo (default 2-bit pixels, 8-pixel rows, depth 16).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sprite_pixel_fifo;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        tick_in;
    logic        flush_in;
    logic        push_valid_in;
    logic        push_ready_out;
    logic [15:0] row_color_in;
    logic [1:0]  row_attr_in;
    logic        flip_in;
    logic        pop_in;
`ifdef SPRITE_FIFO_MIX_EN
    logic        mix_in;
`endif
    logic        pixel_valid_out;
    logic [1:0]  pixel_color_out;
    logic [1:0]  pixel_attr_out;
    logic [4:0]  occupancy_out;
    logic        empty_out;
    logic [1:0]  err_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    sprite_pixel_fifo dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .tick_in         (tick_in),
        .flush_in        (flush_in),
        .push_valid_in   (push_valid_in),
        .push_ready_out  (push_ready_out),
        .row_color_in    (row_color_in),
        .row_attr_in     (row_attr_in),
        .flip_in         (flip_in),
        .pop_in          (pop_in),
`ifdef SPRITE_FIFO_MIX_EN
        .mix_in          (mix_in),
`endif
        .pixel_valid_out (pixel_valid_out),
        .pixel_color_out (pixel_color_out),
        .pixel_attr_out  (pixel_attr_out),
        .occupancy_out   (occupancy_out),
        .empty_out       (empty_out),
        .err_out         (err_out)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_mix [8];
        rst_n_in      = 1'b0;
        tick_in       = 1'b1;
        flush_in      = 1'b0;
        push_valid_in = 1'b0;
        row_color_in  = '0;
        row_attr_in   = '0;
        flip_in       = 1'b0;
        pop_in        = 1'b0;
`ifdef SPRITE_FIFO_MIX_EN
        mix_in        = 1'b0;
`endif
        step();
        step();
        rst_n_in = 1'b1;
        step();

        // Reset state
        chk("rst_occ",   occupancy_out,   0);
        chk("rst_empty", empty_out,       1);
        chk("rst_ready", push_ready_out,  1);
        chk("rst_vld",   pixel_valid_out, 0);
        chk("rst_col",   pixel_color_out, 0);
        chk("rst_err",   err_out,         0);

        // 1: append row, pop in order
        push_valid_in = 1'b1;
        row_color_in  = 16'h1B1B;
        row_attr_in   = 2'b01;
        step();
        push_valid_in = 1'b0;
        chk("t1_occ", occupancy_out, 8);
        pop_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t1_vld%0d", i), pixel_valid_out, 1);
            chk($sformatf("t1_col%0d", i), pixel_color_out, 3 - (i % 4));
            chk($sformatf("t1_att%0d", i), pixel_attr_out, 2'b01);
        end
        pop_in = 1'b0;
        step();
        chk("t1_vld_end", pixel_valid_out, 0);
        chk("t1_empty",   empty_out,       1);
        chk("t1_err",     err_out,         0);

        // Pop with tick low does nothing, not even an underflow error
        tick_in = 1'b0;
        pop_in  = 1'b1;
        step();
        chk("notick_vld", pixel_valid_out, 0);
        chk("notick_err", err_out,         0);
        pop_in  = 1'b0;
        tick_in = 1'b1;

        // 2: flipped row comes out reversed (write pointer wraps 8 -> 0)
        push_valid_in = 1'b1;
        flip_in       = 1'b1;
        row_attr_in   = 2'b10;
        step();
        push_valid_in = 1'b0;
        flip_in       = 1'b0;
        pop_in        = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t2_col%0d", i), pixel_color_out, i % 4);
            chk($sformatf("t2_att%0d", i), pixel_attr_out, 2'b10);
        end
        pop_in = 1'b0;
        step();
        chk("t2_empty", empty_out, 1);

        // Async reset in the middle of activity
        push_valid_in = 1'b1;
        row_color_in  = 16'h5555;
        row_attr_in   = 2'b00;
        step();
        chk("ar_occ_pre", occupancy_out, 8);
        pop_in = 1'b1;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("ar_occ",   occupancy_out,  0);
        chk("ar_empty", empty_out,      1);
        chk("ar_ready", push_ready_out, 1);
        push_valid_in = 1'b0;
        pop_in        = 1'b0;
        step();
        rst_n_in = 1'b1;
        step();
        chk("ar_occ_post", occupancy_out, 0);

        // 3: two rows fill the FIFO, third push overflows
        push_valid_in = 1'b1;
        row_color_in  = 16'h5555;
        step();
        chk("t3_occ8",   occupancy_out,  8);
        chk("t3_rdy8",   push_ready_out, 1);
        row_color_in = 16'hAAAA;
        step();
        chk("t3_occ16",  occupancy_out,  16);
        chk("t3_rdy16",  push_ready_out, 0);
        row_color_in = 16'hFFFF;
        step();
        push_valid_in = 1'b0;
        chk("t3_err",    err_out,        2'b01);
        chk("t3_occovf", occupancy_out,  16);

        // 4: drain to 9, then push+pop ticks
        pop_in = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("t4_col_a", pixel_color_out, 1);
        chk("t4_occ9",  occupancy_out,   9);
        // At 9 a row does not fit: pop proceeds, row is dropped
        push_valid_in = 1'b1;
        row_color_in  = 16'hFFFF;
        step();
        chk("t4_pop9_col", pixel_color_out, 1);
        chk("t4_pop9_occ", occupancy_out,   8);
        chk("t4_pop9_err", err_out,         2'b01);
        // At 8 it fits: pop returns old head, occupancy +7
        step();
        push_valid_in = 1'b0;
        chk("t4_pp_vld", pixel_valid_out, 1);
        chk("t4_pp_col", pixel_color_out, 2);
        chk("t4_pp_occ", occupancy_out,   15);
        chk("t4_pp_rdy", push_ready_out,  0);
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("t4_drain%0d", i), pixel_color_out, (i < 7) ? 2 : 3);
        end
        pop_in = 1'b0;
        step();
        chk("t4_empty", empty_out, 1);

        // 6: flush wins over a push on the same edge, clears errors
        push_valid_in = 1'b1;
        flush_in      = 1'b1;
        step();
        push_valid_in = 1'b0;
        flush_in      = 1'b0;
        chk("t6_occ",   occupancy_out,   0);
        chk("t6_err",   err_out,         0);
        chk("t6_vld",   pixel_valid_out, 0);
        chk("t6_empty", empty_out,       1);
        pop_in = 1'b1;
        step();
        pop_in = 1'b0;
        chk("t6_uf_vld", pixel_valid_out, 0);
        chk("t6_uf_err", err_out,         2'b10);
        chk("t6_uf_occ", occupancy_out,   0);

`ifdef SPRITE_FIFO_MIX_EN
        // 5: queue {0,2,0} then mix a row of colour 1
        flush_in = 1'b1;
        step();
        flush_in      = 1'b0;
        push_valid_in = 1'b1;
        row_color_in  = 16'h2155;   // pixels 1,1,1,1,1,0,2,0
        step();
        push_valid_in = 1'b0;
        pop_in        = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t5_occ3", occupancy_out, 3);
        pop_in        = 1'b0;
        push_valid_in = 1'b1;
        mix_in        = 1'b1;
        row_color_in  = 16'h5555;
        step();
        push_valid_in = 1'b0;
        mix_in        = 1'b0;
        chk("t5_occ8", occupancy_out, 8);
        exp_mix[0] = 2'd1; exp_mix[1] = 2'd2; exp_mix[2] = 2'd1; exp_mix[3] = 2'd1;
        exp_mix[4] = 2'd1; exp_mix[5] = 2'd1; exp_mix[6] = 2'd1; exp_mix[7] = 2'd1;
        pop_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t5_col%0d", i), pixel_color_out, exp_mix[i]);
        end
        pop_in = 1'b0;
        step();
        chk("t5_empty", empty_out, 1);
`else
        exp_mix[0] = 2'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
